// File: rtl/top.sv
// Hamming(7,4)-protected TMR voter: encode three replicas, vote codewords bitwise, correct one bit.
// Latency is 2 cycles with no handshake. Optional VOTER_ERR_INJECT_EN adds inject_en/inject_word.
module top (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] data_1,
  input  logic [3:0] data_2,
  input  logic [3:0] data_3,
`ifdef VOTER_ERR_INJECT_EN
  input  logic       inject_en,
  input  logic [6:0] inject_word,
`endif
  output logic [3:0] voted_q,
  output logic       fault,
  output logic [2:0] lane_err,
  output logic       corrected,
  output logic [2:0] syndrome
);

  // cw[k] holds Hamming position k+1: {d4,d3,d2,p3,d1,p2,p1}
  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p3;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p3 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p3, d[0], p2, p1};
  endfunction

  logic [6:0] cw1, cw2, cw3;
  logic [6:0] data_voted;
  logic [6:0] flip;
  logic [6:0] fixed_word;
  logic [2:0] syn;
  logic [2:0] lane_c;
  logic       fault_c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cw1 <= '0;
      cw2 <= '0;
      cw3 <= '0;
    end else begin
      cw1 <= encode(data_1);
      cw2 <= encode(data_2);
      cw3 <= encode(data_3);
    end
  end

  always_comb begin
    data_voted = (cw1 & cw2) | (cw1 & cw3) | (cw2 & cw3);
`ifdef VOTER_ERR_INJECT_EN
    if (inject_en) data_voted = inject_word;
`endif
    syn[0] = data_voted[0] ^ data_voted[2] ^ data_voted[4] ^ data_voted[6];
    syn[1] = data_voted[1] ^ data_voted[2] ^ data_voted[5] ^ data_voted[6];
    syn[2] = data_voted[3] ^ data_voted[4] ^ data_voted[5] ^ data_voted[6];
    flip = '0;
    for (int k = 0; k < 7; k++) flip[k] = (syn == 3'(k + 1));
    fixed_word = data_voted ^ flip;
    // Fault reflects replica disagreement only, so injection cannot mask it.
    fault_c   = |((cw1 ^ cw2) | (cw1 ^ cw3));
    lane_c[0] = (cw1 != data_voted);
    lane_c[1] = (cw2 != data_voted);
    lane_c[2] = (cw3 != data_voted);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      voted_q   <= '0;
      fault     <= 1'b0;
      lane_err  <= '0;
      corrected <= 1'b0;
      syndrome  <= '0;
    end else begin
      voted_q   <= {fixed_word[6], fixed_word[5], fixed_word[4], fixed_word[2]};
      fault     <= fault_c;
      lane_err  <= lane_c;
      corrected <= |syn;
      syndrome  <= syn;
    end
  end

endmodule

// File: tb/tb_top.sv
// Directed self-checking bench for the Hamming TMR voter.
module tb_top;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] data_1, data_2, data_3;
`ifdef VOTER_ERR_INJECT_EN
  logic       inject_en;
  logic [6:0] inject_word;
`endif
  logic [3:0] voted_q;
  logic       fault;
  logic [2:0] lane_err;
  logic       corrected;
  logic [2:0] syndrome;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_1     (data_1),
    .data_2     (data_2),
    .data_3     (data_3),
`ifdef VOTER_ERR_INJECT_EN
    .inject_en  (inject_en),
    .inject_word(inject_word),
`endif
    .voted_q    (voted_q),
    .fault      (fault),
    .lane_err   (lane_err),
    .corrected  (corrected),
    .syndrome   (syndrome)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] q, input logic f,
                         input logic [2:0] le, input logic c, input logic [2:0] s);
    chk({tag, ".voted_q"},   {4'b0, voted_q},  {4'b0, q});
    chk({tag, ".fault"},     {7'b0, fault},    {7'b0, f});
    chk({tag, ".lane_err"},  {5'b0, lane_err}, {5'b0, le});
    chk({tag, ".corrected"}, {7'b0, corrected},{7'b0, c});
    chk({tag, ".syndrome"},  {5'b0, syndrome}, {5'b0, s});
  endtask

  task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
    data_1 = a;
    data_2 = b;
    data_3 = c;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'h0, 4'h0, 4'h0);
`ifdef VOTER_ERR_INJECT_EN
    inject_en   = 1'b0;
    inject_word = 7'h00;
`endif
    tick();
    tick();
    chk_all("reset", 4'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    rst_n = 1'b1;

    // All replicas agree
    drive(4'b1010, 4'b1010, 4'b1010);
    tick();
    tick();
    chk_all("agree_1010", 4'b1010, 1'b0, 3'b000, 1'b0, 3'b000);

    // Lane 3 is the odd one out
    drive(4'b1100, 4'b1100, 4'b1000);
    tick();
    tick();
    chk_all("odd_lane3", 4'b1100, 1'b1, 3'b100, 1'b0, 3'b000);

    // Back-to-back, lane 2 odd both times
    drive(4'b1001, 4'b1010, 4'b1001);
    tick();
    drive(4'b1011, 4'b0110, 4'b1011);
    tick();
    chk_all("b2b_first", 4'b1001, 1'b1, 3'b010, 1'b0, 3'b000);
    tick();
    chk_all("b2b_second", 4'b1011, 1'b1, 3'b010, 1'b0, 3'b000);

    // Lane 1 odd
    drive(4'b0111, 4'b0011, 4'b0011);
    tick();
    tick();
    chk_all("odd_lane1", 4'b0011, 1'b1, 3'b001, 1'b0, 3'b000);

    // All different: codewords 0000111,0011001,0101010 vote to 0001011, syndrome 7 flips bit 6
    drive(4'b0001, 4'b0010, 4'b0100);
    tick();
    tick();
    chk_all("all_diff", 4'b1000, 1'b1, 3'b111, 1'b1, 3'b111);

`ifdef VOTER_ERR_INJECT_EN
    drive(4'b1010, 4'b1010, 4'b1010);
    tick();
    inject_en   = 1'b1;
    inject_word = 7'b1010011;
    tick();
    chk_all("inject_pos1", 4'b1010, 1'b0, 3'b111, 1'b1, 3'b001);
    inject_en = 1'b0;
    tick();
    inject_en   = 1'b1;
    inject_word = 7'b0010010;
    tick();
    chk_all("inject_pos7", 4'b1010, 1'b0, 3'b111, 1'b1, 3'b111);
    inject_en = 1'b0;
    tick();
    chk_all("inject_off", 4'b1010, 1'b0, 3'b000, 1'b0, 3'b000);
`endif

    // Reset mid-stream: in-flight 0101 must never surface
    drive(4'b0101, 4'b0101, 4'b0101);
    tick();
    drive(4'b1111, 4'b1111, 4'b1010);
    rst_n = 1'b0;
    tick();
    chk_all("midrst_hold", 4'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    rst_n = 1'b1;
    tick();
    chk_all("midrst_cyc2", 4'b0, 1'b0, 3'b000, 1'b0, 3'b000);
    tick();
    chk_all("midrst_valid", 4'b1111, 1'b1, 3'b100, 1'b0, 3'b000);

    // Every value on all three replicas passes through unchanged
    for (int v = 0; v < 16; v++) begin
      drive(4'(v), 4'(v), 4'(v));
      tick();
      tick();
      chk($sformatf("exh_q_%0d", v), {4'b0, voted_q}, 8'(v));
      chk($sformatf("exh_fault_%0d", v), {7'b0, fault}, 8'h00);
      chk($sformatf("exh_corr_%0d", v), {7'b0, corrected}, 8'h00);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/top.md
Name: top

Overview:
- Hamming-protected triple-modular-redundancy (TMR) voter.
- Each of three 4-bit replica inputs is encoded into a Hamming(7,4) codeword, then the three codewords are majority-voted bitwise.
- The voted codeword is syndrome-decoded with single-bit correction, giving one 4-bit result plus fault status flags.
- Sits at the output of triplicated logic, ahead of any single-string consumer.

Parameters:
- None. Data width is fixed at 4 bits and codeword width at 7 bits.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active low
- data_1  input  4  replica 1 data
- data_2  input  4  replica 2 data
- data_3  input  4  replica 3 data
- voted_q  output  4  voted, Hamming-corrected data
- fault  output  1  the three codewords were not all identical
- lane_err  output  3  bit i set when replica i+1 codeword differs from the voted codeword
- corrected  output  1  decoder syndrome nonzero; one codeword bit was flipped back
- syndrome  output  3  decoder syndrome; nonzero value is the 1-based position of the flipped bit

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, rst_n).
- Data bit mapping: d1=data[0], d2=data[1], d3=data[2], d4=data[3].
- Parity: p1=d1^d2^d4, p2=d1^d3^d4, p3=d2^d3^d4.
- Codeword bit order, cw[6:0] = {d4,d3,d2,p3,d1,p2,p1}, so cw[k] holds Hamming position k+1.
- Stage 1 (registered): encode data_1/2/3 into cw1/cw2/cw3 and register them.
- Stage 2 (combinational, then registered):
  - Vote: data_voted = (cw1&cw2)|(cw1&cw3)|(cw2&cw3), bitwise.
  - Syndrome bits:
    - s1 = xor of positions 1,3,5,7.
    - s2 = xor of positions 2,3,6,7.
    - s3 = xor of positions 4,5,6,7.
  - syndrome = {s3,s2,s1}. If nonzero, invert bit position syndrome in data_voted.
  - Extract voted_q = {cw[6],cw[5],cw[4],cw[2]} of the corrected word.
- Flag computation:
  - fault = |((cw1^cw2)|(cw1^cw3)).
  - lane_err[i] = (cw_{i+1} != data_voted).
  - corrected = |syndrome.
- Registration and latency:
  - voted_q, fault, lane_err, corrected and syndrome are all registered at the end of stage 2.
  - Latency is 2 cycles from input sample to output; throughput is one result per cycle, with no handshake.
- Reset: while rst_n=0 at a rising edge, the stage-1 codeword registers and all outputs clear to 0. Outputs read 0 for the first 2 cycles after deassertion, until new data propagates.
- Reset asserted mid-stream: in-flight data is discarded and no stale result appears afterwards.
- Boundary cases:
  - All three replicas different: bitwise vote still applies, then the decoder corrects at most one bit. The result is deterministic but need not equal any single input. fault=1.
  - Two replicas agree: voted_q equals the agreeing value, corrected=0, fault=1, and the odd lane's lane_err bit is set.
  - All replicas agree: fault=0, lane_err=000.
- The Hamming code detects no double-bit errors; none are reported.

Optional Feature:
- Macro VOTER_ERR_INJECT_EN.
- When defined, two extra ports are added: inject_en (input, 1) and inject_word (input, 7). While inject_en=1, data_voted is replaced by inject_word before syndrome decode, in the same cycle it would be voted.
  - lane_err is computed against the injected word.
  - fault is unaffected.
- When undefined, neither port exists and the vote always drives decode.

Test Plan:
- All replicas 1010 -> after 2 cycles voted_q=1010, fault=0, lane_err=000, corrected=0, syndrome=000.
- 1100,1100,1000 -> voted_q=1100, fault=1, lane_err=100, corrected=0.
- 1001,1010,1001 and 1011,0110,1011 back to back -> voted_q=1001 then 1011 on consecutive cycles, lane_err=010 both times.
- Inject (VOTER_ERR_INJECT_EN), all data 1010 (codeword 1010010):
  - inject_word=1010011 -> voted_q=1010, corrected=1, syndrome=001.
  - inject_word=0010010 -> voted_q=1010, syndrome=111.
- rst_n=0 for 1 cycle mid-stream with data 1111,1111,1010 -> outputs all 0 for 2 cycles after release, then voted_q=1111, fault=1, lane_err=100.
- Exhaustive: every 4-bit value on all three replicas -> voted_q equals the input, fault=0.
